// File: rtl/uart_monitor_mc.sv
// Multi-channel UART telemetry tap: snapshots N_CH signed values on a trigger and
// streams them as one ASCII line (fixed-width decimal or hex fields) over TX-only UART.
module uart_monitor_mc #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned VAL_W     = 16,
  parameter int unsigned CLK_DIV   = 217,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CRLF      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_hex,
  input  logic [N_CH*VAL_W-1:0]   i_vals,
  output logic                    o_busy,
  output logic [7:0]              o_drop_cnt,
  output logic                    o_uart_tx
);

  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = 64'd1 << (w - 1);
    n = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  localparam int unsigned D     = dec_digits(VAL_W);
  localparam int unsigned H     = (VAL_W + 3) / 4;
  localparam int unsigned FMAX  = D + 1;
  localparam int unsigned POS_W = $clog2(FMAX + 1);
  localparam int unsigned CH_W  = $clog2(N_CH + 1);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned NB    = 9 + STOP_BITS;
  localparam int unsigned SR_W  = 8 + STOP_BITS;
  localparam int unsigned BIT_W = $clog2(NB);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_SEND, S_TERM} state_t;

  state_t              state_q;
  logic                busy_q;
  logic [7:0]          drop_q;
  logic                hex_q;
  logic [VAL_W-1:0]    vals_q [N_CH];
  logic [CH_W-1:0]     cvt_ch_q;
  logic [CH_W-1:0]     snd_ch_q;
  logic [FMAX*8-1:0]   fld_q;
  logic [POS_W-1:0]    idx_q;
  logic                term_q;
  logic                term_sent_q;
  logic [7:0]          hold_q;
  logic                hold_v_q;

  logic                cv_busy_q;
  logic                cv_done_q;
  logic                cv_hex_q;
  logic                cv_neg_q;
  logic                cv_sign_q;
  logic [VAL_W-1:0]    cv_mag_q;
  logic [POS_W-1:0]    cv_cnt_q;
  logic [FMAX*8-1:0]   cv_buf_q;

  logic                tx_q;
  logic                tx_act_q;
  logic [SR_W-1:0]     tx_sr_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;

  logic                cv_kick_d;
  logic                cv_take_d;
  logic                cv_last_d;
  logic [POS_W-1:0]    cv_pos_d;
  logic [VAL_W-1:0]    sel_val_d;
  logic [VAL_W-1:0]    mag_mod_d;
  logic [VAL_W-1:0]    mag_div_d;
  logic [3:0]          nib_d;
  logic [7:0]          cv_char_d;
  logic [VAL_W-1:0]    cv_mag_d;
  logic                cv_sign_d;
  logic                tx_bit_end_d;
  logic                tx_frame_end_d;
  logic                tx_take_d;

  // Converter prefetches the next channel whenever its result buffer is free
  assign cv_kick_d = (state_q == S_LOAD || state_q == S_CONV || state_q == S_SEND)
                     && !cv_busy_q && !cv_done_q && (cvt_ch_q < CH_W'(N_CH));
  assign cv_take_d = (state_q == S_CONV) && cv_done_q;
  assign sel_val_d = vals_q[IDX_W'(cvt_ch_q)];
  assign cv_last_d = cv_hex_q ? (cv_cnt_q == POS_W'(H - 1)) : (cv_cnt_q == POS_W'(D));
  assign cv_pos_d  = POS_W'(FMAX - 1) - cv_cnt_q;
  assign mag_mod_d = cv_mag_q % VAL_W'(10);
  assign mag_div_d = cv_mag_q / VAL_W'(10);
  assign nib_d     = cv_mag_q[3:0];

  // One character per cycle, filled from the rightmost field position leftwards
  always_comb begin
    cv_char_d = 8'h20;
    cv_mag_d  = cv_mag_q;
    cv_sign_d = cv_sign_q;
    if (cv_hex_q) begin
      cv_char_d = (nib_d < 4'd10) ? 8'h30 + 8'(nib_d) : 8'h37 + 8'(nib_d);
      cv_mag_d  = cv_mag_q >> 4;
    end else begin
      cv_mag_d = mag_div_d;
      if (cv_cnt_q == '0 || cv_mag_q != '0) begin
        cv_char_d = 8'h30 + 8'(mag_mod_d);
      end else if (!cv_sign_q) begin
        cv_char_d = cv_neg_q ? 8'h2D : 8'h20;
        cv_sign_d = 1'b1;
      end
    end
  end

  assign tx_bit_end_d   = (div_q == DIV_W'(CLK_DIV - 1));
  assign tx_frame_end_d = tx_act_q && tx_bit_end_d && (bit_q == BIT_W'(NB - 1));
  assign tx_take_d      = hold_v_q && (!tx_act_q || tx_frame_end_d);

  // Line sequencer: snapshot, field hand-off, separators and terminator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      drop_q      <= 8'd0;
      hex_q       <= 1'b0;
      cvt_ch_q    <= '0;
      snd_ch_q    <= '0;
      idx_q       <= '0;
      term_q      <= 1'b0;
      term_sent_q <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_q      <= 8'h00;
    end else begin
      if (tx_take_d) hold_v_q <= 1'b0;
      if (cv_kick_d) cvt_ch_q <= cvt_ch_q + 1'b1;
      if (i_en && state_q != S_IDLE && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      case (state_q)
        S_IDLE: begin
          if (i_en) begin
            for (int unsigned k = 0; k < N_CH; k++) vals_q[k] <= i_vals[k*VAL_W +: VAL_W];
            hex_q       <= i_hex;
            busy_q      <= 1'b1;
            cvt_ch_q    <= '0;
            snd_ch_q    <= '0;
            term_q      <= 1'b0;
            term_sent_q <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: state_q <= S_CONV;
        S_CONV: begin
          if (cv_done_q) begin
            fld_q   <= cv_buf_q;
            idx_q   <= hex_q ? POS_W'(FMAX - H) : '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (!hold_v_q) begin
            if (idx_q != POS_W'(FMAX)) begin
              hold_q   <= fld_q[{idx_q, 3'b000} +: 8];
              hold_v_q <= 1'b1;
              idx_q    <= idx_q + 1'b1;
            end else if (snd_ch_q == CH_W'(N_CH - 1)) begin
              state_q <= S_TERM;
            end else begin
              hold_q   <= 8'h20;
              hold_v_q <= 1'b1;
              snd_ch_q <= snd_ch_q + 1'b1;
              state_q  <= S_LOAD;
            end
          end
        end
        S_TERM: begin
          if (!term_sent_q) begin
            if (!hold_v_q) begin
              hold_v_q <= 1'b1;
              if (CRLF != 0 && !term_q) begin
                hold_q <= 8'h0D;
                term_q <= 1'b1;
              end else begin
                hold_q      <= 8'h0A;
                term_sent_q <= 1'b1;
              end
            end
          end else if (!hold_v_q && !tx_act_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Binary to text: divide-by-10 per digit for decimal, nibble shift for hex
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_busy_q <= 1'b0;
      cv_done_q <= 1'b0;
      cv_hex_q  <= 1'b0;
      cv_neg_q  <= 1'b0;
      cv_sign_q <= 1'b0;
      cv_cnt_q  <= '0;
      cv_mag_q  <= '0;
    end else begin
      if (cv_take_d) cv_done_q <= 1'b0;
      if (cv_kick_d) begin
        cv_busy_q <= 1'b1;
        cv_cnt_q  <= '0;
        cv_hex_q  <= hex_q;
        cv_neg_q  <= sel_val_d[VAL_W-1];
        cv_sign_q <= 1'b0;
        cv_mag_q  <= (hex_q || !sel_val_d[VAL_W-1]) ? sel_val_d : (~sel_val_d + VAL_W'(1));
      end else if (cv_busy_q) begin
        cv_buf_q[{cv_pos_d, 3'b000} +: 8] <= cv_char_d;
        cv_mag_q  <= cv_mag_d;
        cv_sign_q <= cv_sign_d;
        cv_cnt_q  <= cv_cnt_q + 1'b1;
        if (cv_last_d) begin
          cv_busy_q <= 1'b0;
          cv_done_q <= 1'b1;
        end
      end
    end
  end

  // UART serializer; a waiting byte starts right as the previous stop bit ends
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= 1'b1;
      tx_act_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_sr_q  <= '1;
    end else if (tx_take_d) begin
      tx_q     <= 1'b0;
      tx_sr_q  <= {{STOP_BITS{1'b1}}, hold_q};
      tx_act_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (tx_act_q) begin
      if (tx_bit_end_d) begin
        div_q <= '0;
        if (bit_q == BIT_W'(NB - 1)) begin
          tx_act_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          tx_q    <= tx_sr_q[0];
          tx_sr_q <= {1'b1, tx_sr_q[SR_W-1:1]};
          bit_q   <= bit_q + 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;
  assign o_uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_monitor_mc.sv
// Scoreboard bench: three monitor configurations, expected line bytes queued per
// instance and checked by UART decoders running alongside the stimulus.
module tb_uart_monitor_mc;

  logic        clk;
  logic        rst_a, rst_bc;
  logic        en_a, en_b, en_c;
  logic        hex_a, hex_b, hex_c;
  logic [63:0] vals_a, vals_b;
  logic [31:0] vals_c;
  logic        busy_a, busy_b, busy_c;
  logic [7:0]  drop_a, drop_b, drop_c;
  logic        tx_a, tx_b, tx_c;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int en_cyc [3];
  bit first_byte [3];
  bit discard [3];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] q_c [$];

  localparam logic [63:0] TEST_VALS = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};

  uart_monitor_mc #(.N_CH(4), .VAL_W(16), .CLK_DIV(4), .STOP_BITS(1), .CRLF(0)) u_a (
    .clk(clk), .rst(rst_a), .i_en(en_a), .i_hex(hex_a), .i_vals(vals_a),
    .o_busy(busy_a), .o_drop_cnt(drop_a), .o_uart_tx(tx_a));

  uart_monitor_mc #(.N_CH(4), .VAL_W(16), .CLK_DIV(7), .STOP_BITS(2), .CRLF(1)) u_b (
    .clk(clk), .rst(rst_bc), .i_en(en_b), .i_hex(hex_b), .i_vals(vals_b),
    .o_busy(busy_b), .o_drop_cnt(drop_b), .o_uart_tx(tx_b));

  uart_monitor_mc #(.N_CH(1), .VAL_W(32), .CLK_DIV(4), .STOP_BITS(1), .CRLF(0)) u_c (
    .clk(clk), .rst(rst_bc), .i_en(en_c), .i_hex(hex_c), .i_vals(vals_c),
    .o_busy(busy_c), .o_drop_cnt(drop_c), .o_uart_tx(tx_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic tx_of(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int drop_of(input int w);
    case (w)
      0:       return int'(drop_a);
      1:       return int'(drop_b);
      default: return int'(drop_c);
    endcase
  endfunction

  task automatic set_en(input int w, input logic v);
    case (w)
      0:       en_a = v;
      1:       en_b = v;
      default: en_c = v;
    endcase
  endtask

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    check(name, act == exp, act, exp);
  endtask

  task automatic push_line(input int w, input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (w)
        0:       q_a.push_back(s[i]);
        1:       q_b.push_back(s[i]);
        default: q_c.push_back(s[i]);
      endcase
    end
  endtask

  task automatic pop_exp(input int w, output bit have, output logic [7:0] e);
    have = 1'b0;
    e    = 8'h00;
    case (w)
      0:       if (q_a.size() > 0) begin have = 1'b1; e = q_a.pop_front(); end
      1:       if (q_b.size() > 0) begin have = 1'b1; e = q_b.pop_front(); end
      default: if (q_c.size() > 0) begin have = 1'b1; e = q_c.pop_front(); end
    endcase
  endtask

  task automatic issue(input int w);
    @(negedge clk);
    set_en(w, 1'b1);
    @(negedge clk);
    set_en(w, 1'b0);
    en_cyc[w]     = cyc;
    first_byte[w] = 1'b1;
    chk_eq("busy_after_trigger", busy_of(w), 1);
  endtask

  task automatic drop_pulse(input int w);
    @(negedge clk);
    set_en(w, 1'b1);
    @(negedge clk);
    set_en(w, 1'b0);
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (busy_of(w) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("line_completes", busy_of(w), 0);
    repeat (5) @(negedge clk);
  endtask

  // UART decoder: frame timing, stop bits and byte values against the queue
  task automatic monitor(input int w, input int div, input int nb, input int dmax);
    logic       prev, cur, have;
    logic [7:0] b, e;
    int         st, last_st;
    prev    = 1'b1;
    last_st = 0;
    forever begin
      @(negedge clk);
      cur = tx_of(w);
      if (prev && !cur) begin
        st = cyc;
        if (first_byte[w]) begin
          first_byte[w] = 1'b0;
          check("first_start_latency", (st - en_cyc[w]) <= dmax + 6, st - en_cyc[w], dmax + 6);
        end else begin
          chk_eq("byte_spacing", st - last_st, nb * div);
        end
        last_st = st;
        repeat (div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge clk);
          b[i] = tx_of(w);
        end
        if (discard[w]) begin
          discard[w] = 1'b0;
        end else begin
          for (int s = 0; s < nb - 9; s++) begin
            repeat (div) @(negedge clk);
            chk_eq("stop_bit", tx_of(w), 1);
          end
          pop_exp(w, have, e);
          if (!have) check("rx_extra_byte", 1'b0, b, -1);
          else       chk_eq("rx_byte", b, e);
        end
        cur = tx_of(w);
      end
      prev = cur;
    end
  endtask

  initial monitor(0, 4, 10, 5);
  initial monitor(1, 7, 11, 5);
  initial monitor(2, 4, 10, 10);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    hex_a = 1'b0; hex_b = 1'b0; hex_c = 1'b0;
    vals_a = TEST_VALS; vals_b = TEST_VALS; vals_c = 32'h8000_0000;
    for (int w = 0; w < 3; w++) begin
      en_cyc[w] = 0; first_byte[w] = 1'b0; discard[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk_eq("reset_tx", tx_of(w), 1);
      chk_eq("reset_busy", busy_of(w), 0);
      chk_eq("reset_drop", drop_of(w), 0);
    end
    rst_a = 1'b0; rst_bc = 1'b0;
    repeat (2) @(negedge clk);

    // Decimal line; inputs change and triggers arrive mid-line
    push_line(0, "     0     -1  32767 -32768\n");
    issue(0);
    repeat (100) @(negedge clk);
    vals_a = 64'h1111_2222_3333_4444;
    hex_a  = 1'b1;
    repeat (3) drop_pulse(0);
    @(negedge clk);
    chk_eq("drop_count_3", drop_a, 3);
    wait_idle(0);

    // Hex line while the drop counter is pushed into saturation
    vals_a = TEST_VALS;
    hex_a  = 1'b1;
    push_line(0, "0000 FFFF 7FFF 8000\n");
    issue(0);
    repeat (300) drop_pulse(0);
    @(negedge clk);
    chk_eq("drop_count_sat", drop_a, 255);
    chk_eq("busy_during_drops", busy_a, 1);
    wait_idle(0);

    // Reset during data bit 3 of byte 2, then a fresh line
    hex_a = 1'b0;
    push_line(0, "     0     -1  32767 -32768\n");
    issue(0);
    while (cyc < en_cyc[0] + 107) @(negedge clk);
    rst_a      = 1'b1;
    discard[0] = 1'b1;
    q_a.delete();
    @(negedge clk);
    rst_a = 1'b0;
    chk_eq("abort_tx_idle", tx_a, 1);
    chk_eq("abort_busy", busy_a, 0);
    chk_eq("abort_drop_clear", drop_a, 0);
    repeat (60) @(negedge clk);
    vals_a = {16'hFFF9, 16'h3039, 16'hFF9C, 16'h0001};
    push_line(0, "     1   -100  12345     -7\n");
    issue(0);
    wait_idle(0);

    // CRLF terminator, 2 stop bits, CLK_DIV=7
    hex_b = 1'b1;
    push_line(1, "0000 FFFF 7FFF 8000\r\n");
    issue(1);
    wait_idle(1);
    hex_b = 1'b0;
    push_line(1, "     0     -1  32767 -32768\r\n");
    issue(1);
    wait_idle(1);

    // Single 32-bit channel
    vals_c = 32'h8000_0000; hex_c = 1'b0;
    push_line(2, "-2147483648\n");
    issue(2);
    wait_idle(2);
    hex_c = 1'b1;
    push_line(2, "80000000\n");
    issue(2);
    wait_idle(2);
    vals_c = 32'h7FFF_FFFF; hex_c = 1'b0;
    push_line(2, " 2147483647\n");
    issue(2);
    wait_idle(2);
    vals_c = 32'd5;
    push_line(2, "          5\n");
    issue(2);
    wait_idle(2);

    repeat (20) @(negedge clk);
    chk_eq("queue_a_drained", q_a.size(), 0);
    chk_eq("queue_b_drained", q_b.size(), 0);
    chk_eq("queue_c_drained", q_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
